// File: rtl/vliw_pkg.sv
// Shared types for the 3-slot VLIW pipeline: register/control widths, FSM
// states and the ID/EX bundle layout (also used by EX/MEM).
package vliw_pkg;

  localparam int REG_W  = 3;
  localparam int CTRL_W = 8;
  localparam logic [REG_W-1:0] R0 = '0;

  typedef enum logic {RUN, STALL} state_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              ld;
    logic              st;
    logic [REG_W-1:0]  rn1;
    logic [REG_W-1:0]  rd1;
    logic [REG_W-1:0]  rn2;
    logic [REG_W-1:0]  rd2;
    logic [REG_W-1:0]  rd3;
    logic [CTRL_W-1:0] ctrl1;
    logic [CTRL_W-1:0] ctrl2;
  } bundle_t;

endpackage

// File: rtl/id_ex_hazard_stage_load_use_detect.sv
// Load-use comparator: a load sitting in EX whose destination feeds any
// source of the bundle waiting in ID. r0 never creates a dependency.
module load_use_detect
  import vliw_pkg::*;
(
  input  logic             id_valid,
  input  logic             ex_valid,
  input  logic             ex_ld,
  input  logic [REG_W-1:0] ex_rd3,
  input  logic [REG_W-1:0] id_rn1,
  input  logic [REG_W-1:0] id_rd1,
  input  logic [REG_W-1:0] id_rn2,
  input  logic [REG_W-1:0] id_rd2,
  output logic             hz
);

  logic match;

  // Slots 1/2 are two-address, so Rd is a source as well as the destination.
  assign match = (ex_rd3 == id_rn1) | (ex_rd3 == id_rd1) |
                 (ex_rd3 == id_rn2) | (ex_rd3 == id_rd2);

  assign hz = id_valid & ex_valid & ex_ld & (ex_rd3 != R0) & match;

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use interlock: stalls IF/ID and inserts
// LOAD_STALL bubbles when a load in EX feeds the bundle waiting in ID.
module id_ex_hazard_stage
  import vliw_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rn1,
  input  logic [REG_W-1:0]  id_rd1,
  input  logic [REG_W-1:0]  id_rn2,
  input  logic [REG_W-1:0]  id_rd2,
  input  logic [REG_W-1:0]  id_rd3,
  input  logic              id_regwrite,
  input  logic              id_ld3,
  input  logic              id_st3,
  input  logic [CTRL_W-1:0] id_ctrl1,
  input  logic [CTRL_W-1:0] id_ctrl2,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall_o,
  output logic              id_ex_valid,
  output logic              id_ex_regwrite,
  output logic              id_ex_ld,
  output logic              id_ex_st,
  output logic [REG_W-1:0]  id_ex_rn1,
  output logic [REG_W-1:0]  id_ex_rd1,
  output logic [REG_W-1:0]  id_ex_rn2,
  output logic [REG_W-1:0]  id_ex_rd2,
  output logic [REG_W-1:0]  id_ex_rd3,
  output logic [CTRL_W-1:0] id_ex_ctrl1,
  output logic [CTRL_W-1:0] id_ex_ctrl2,
  output logic [PERF_W-1:0] stall_cycles
);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  bundle_t             id_ex_q, id_ex_d, cap;
  logic [PERF_W-1:0]   perf_q;
  logic                perf_inc;
  logic                hz;

  load_use_detect u_detect (
    .id_valid (id_valid),
    .ex_valid (id_ex_q.valid),
    .ex_ld    (id_ex_q.ld),
    .ex_rd3   (id_ex_q.rd3),
    .id_rn1   (id_rn1),
    .id_rd1   (id_rd1),
    .id_rn2   (id_rn2),
    .id_rd2   (id_rd2),
    .hz       (hz)
  );

  // Invalid bundles still latch their fields but never carry live control.
  always_comb begin
    cap          = '0;
    cap.valid    = id_valid;
    cap.regwrite = id_valid & id_regwrite;
    cap.ld       = id_valid & id_ld3;
    cap.st       = id_valid & id_st3;
    cap.rn1      = id_rn1;
    cap.rd1      = id_rd1;
    cap.rn2      = id_rn2;
    cap.rd2      = id_rd2;
    cap.rd3      = id_rd3;
    cap.ctrl1    = id_ctrl1;
    cap.ctrl2    = id_ctrl2;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    id_ex_d  = id_ex_q;
    stall_o  = 1'b0;
    perf_inc = 1'b0;
    if (flush) begin
      id_ex_d = '0;
      state_d = RUN;
      cnt_d   = '0;
    end else if (ex_hold) begin
      stall_o = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (hz) begin
            stall_o  = 1'b1;
            id_ex_d  = '0;
            perf_inc = 1'b1;
            if (LOAD_STALL > 1) begin
              state_d = STALL;
              cnt_d   = 3'(LOAD_STALL - 1);
            end
          end else begin
            id_ex_d = cap;
          end
        end
        STALL: begin
          stall_o  = 1'b1;
          id_ex_d  = '0;
          perf_inc = 1'b1;
          cnt_d    = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RUN;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      id_ex_q <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_ex_q <= id_ex_d;
      if (perf_inc && (perf_q != {PERF_W{1'b1}}))
        perf_q <= perf_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end
  end

  assign id_ex_valid    = id_ex_q.valid;
  assign id_ex_regwrite = id_ex_q.regwrite;
  assign id_ex_ld       = id_ex_q.ld;
  assign id_ex_st       = id_ex_q.st;
  assign id_ex_rn1      = id_ex_q.rn1;
  assign id_ex_rd1      = id_ex_q.rd1;
  assign id_ex_rn2      = id_ex_q.rn2;
  assign id_ex_rd2      = id_ex_q.rd2;
  assign id_ex_rd3      = id_ex_q.rd3;
  assign id_ex_ctrl1    = id_ex_q.ctrl1;
  assign id_ex_ctrl2    = id_ex_q.ctrl2;
  assign stall_cycles   = perf_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench: three instances (LOAD_STALL 1/3/2) share one ID stream;
// instance 0 uses a 2-bit perf counter so saturation is reachable.
module tb_id_ex_hazard_stage;

  logic       clk, rst_n;
  logic       id_valid, id_regwrite, id_ld3, id_st3, flush, ex_hold;
  logic [2:0] id_rn1, id_rd1, id_rn2, id_rd2, id_rd3;
  logic [7:0] id_ctrl1, id_ctrl2;

  logic       stall [3];
  logic       v [3], rw [3], ld [3], st [3];
  logic [2:0] rn1 [3], rd1 [3], rn2 [3], rd2 [3], rd3 [3];
  logic [7:0] c1 [3], c2 [3];
  logic [1:0]  sc_a;
  logic [15:0] sc_b, sc_c;

  int errors = 0;
  int checks = 0;

  id_ex_hazard_stage #(.LOAD_STALL(1), .PERF_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rn1(id_rn1), .id_rd1(id_rd1), .id_rn2(id_rn2), .id_rd2(id_rd2), .id_rd3(id_rd3),
    .id_regwrite(id_regwrite), .id_ld3(id_ld3), .id_st3(id_st3),
    .id_ctrl1(id_ctrl1), .id_ctrl2(id_ctrl2), .flush(flush), .ex_hold(ex_hold),
    .stall_o(stall[0]), .id_ex_valid(v[0]), .id_ex_regwrite(rw[0]), .id_ex_ld(ld[0]),
    .id_ex_st(st[0]), .id_ex_rn1(rn1[0]), .id_ex_rd1(rd1[0]), .id_ex_rn2(rn2[0]),
    .id_ex_rd2(rd2[0]), .id_ex_rd3(rd3[0]), .id_ex_ctrl1(c1[0]), .id_ex_ctrl2(c2[0]),
    .stall_cycles(sc_a));

  id_ex_hazard_stage #(.LOAD_STALL(3), .PERF_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rn1(id_rn1), .id_rd1(id_rd1), .id_rn2(id_rn2), .id_rd2(id_rd2), .id_rd3(id_rd3),
    .id_regwrite(id_regwrite), .id_ld3(id_ld3), .id_st3(id_st3),
    .id_ctrl1(id_ctrl1), .id_ctrl2(id_ctrl2), .flush(flush), .ex_hold(ex_hold),
    .stall_o(stall[1]), .id_ex_valid(v[1]), .id_ex_regwrite(rw[1]), .id_ex_ld(ld[1]),
    .id_ex_st(st[1]), .id_ex_rn1(rn1[1]), .id_ex_rd1(rd1[1]), .id_ex_rn2(rn2[1]),
    .id_ex_rd2(rd2[1]), .id_ex_rd3(rd3[1]), .id_ex_ctrl1(c1[1]), .id_ex_ctrl2(c2[1]),
    .stall_cycles(sc_b));

  id_ex_hazard_stage #(.LOAD_STALL(2), .PERF_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rn1(id_rn1), .id_rd1(id_rd1), .id_rn2(id_rn2), .id_rd2(id_rd2), .id_rd3(id_rd3),
    .id_regwrite(id_regwrite), .id_ld3(id_ld3), .id_st3(id_st3),
    .id_ctrl1(id_ctrl1), .id_ctrl2(id_ctrl2), .flush(flush), .ex_hold(ex_hold),
    .stall_o(stall[2]), .id_ex_valid(v[2]), .id_ex_regwrite(rw[2]), .id_ex_ld(ld[2]),
    .id_ex_st(st[2]), .id_ex_rn1(rn1[2]), .id_ex_rd1(rd1[2]), .id_ex_rn2(rn2[2]),
    .id_ex_rd2(rd2[2]), .id_ex_rd3(rd3[2]), .id_ex_ctrl1(c1[2]), .id_ex_ctrl2(c2[2]),
    .stall_cycles(sc_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] regs_of(input int i);
    return {v[i], rw[i], ld[i], st[i], rn1[i], rd1[i], rn2[i], rd2[i], rd3[i], c1[i], c2[i]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_b(input logic vv, input logic [2:0] a_rn1, a_rd1, a_rn2, a_rd2, a_rd3,
                       input logic a_rw, a_ld, a_st, input logic [7:0] a_c1, a_c2);
    id_valid = vv; id_rn1 = a_rn1; id_rd1 = a_rd1; id_rn2 = a_rn2; id_rd2 = a_rd2;
    id_rd3 = a_rd3; id_regwrite = a_rw; id_ld3 = a_ld; id_st3 = a_st;
    id_ctrl1 = a_c1; id_ctrl2 = a_c2;
  endtask

  task automatic idle();
    set_b(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic apply_reset();
    idle();
    flush = 0; ex_hold = 0;
    tick();
    rst_n = 0;
    #2;
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    idle(); flush = 0; ex_hold = 0; rst_n = 0;
    tick(); tick();
    rst_n = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (regs_of(i) !== 36'h0) begin
        errors++; $display("FAIL reset_regs inst%0d: got %h expected 0", i, regs_of(i));
      end
    end
    checks++;
    if ({sc_a, sc_b, sc_c} !== 34'h0) begin
      errors++; $display("FAIL reset_perf: got %h expected 0", {sc_a, sc_b, sc_c});
    end
    set_b(1, 2, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00);
    tick();
    checks++;
    if (rn1[0] !== 3'd2 || rw[0] !== 1'b1) begin
      errors++; $display("FAIL capture_pre_reset: got rn1=%0d rw=%b expected rn1=2 rw=1", rn1[0], rw[0]);
    end
    set_b(1, 0, 0, 0, 0, 3, 0, 1, 0, 8'h00, 8'h00);
    tick();
    set_b(1, 3, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00);
    tick();
    checks++;
    if (stall[1] !== 1'b1) begin
      errors++; $display("FAIL stall_before_reset: got %b expected 1", stall[1]);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (v[0] !== 1'b0 || rn1[0] !== 3'd0 || rw[0] !== 1'b0 || stall[0] !== 1'b0) begin
      errors++; $display("FAIL async_reset: got v=%b rn1=%0d rw=%b stall=%b expected all 0",
                         v[0], rn1[0], rw[0], stall[0]);
    end
    checks++;
    if (stall[1] !== 1'b0) begin
      errors++; $display("FAIL reset_mid_stall: got %b expected 0", stall[1]);
    end
    tick();
    rst_n = 1;
    idle();
    tick();
    checks++;
    if (stall[1] !== 1'b0 || v[1] !== 1'b0) begin
      errors++; $display("FAIL no_stall_resume: got stall=%b v=%b expected 0 0", stall[1], v[1]);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    set_b(1, 0, 0, 0, 0, 3, 0, 1, 0, 8'h00, 8'h00);
    #1;
    checks++;
    if (stall[0] !== 1'b0) begin
      errors++; $display("FAIL lu_no_stall_on_load: got %b expected 0", stall[0]);
    end
    tick();
    set_b(1, 0, 0, 3, 0, 0, 1, 0, 0, 8'h11, 8'h22);
    #1;
    checks++;
    if (stall[0] !== 1'b1) begin
      errors++; $display("FAIL lu_stall: got %b expected 1", stall[0]);
    end
    tick();
    checks++;
    if (v[0] !== 1'b0 || sc_a !== 2'd1) begin
      errors++; $display("FAIL lu_bubble: got v=%b sc=%0d expected v=0 sc=1", v[0], sc_a);
    end
    checks++;
    if (stall[0] !== 1'b0) begin
      errors++; $display("FAIL lu_stall_release: got %b expected 0", stall[0]);
    end
    tick();
    checks++;
    if (v[0] !== 1'b1 || rn2[0] !== 3'd3 || c2[0] !== 8'h22 || sc_a !== 2'd1) begin
      errors++; $display("FAIL lu_capture: got v=%b rn2=%0d c2=%h sc=%0d expected 1 3 22 1",
                         v[0], rn2[0], c2[0], sc_a);
    end
  endtask

  task automatic test_no_hazard();
    logic seen;
    apply_reset();
    seen = 0;
    set_b(1, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00); tick();
    set_b(1, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00); #1; seen |= stall[0]; tick();
    set_b(1, 0, 0, 0, 0, 4, 0, 0, 1, 8'h00, 8'h00); tick();
    set_b(1, 0, 4, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00); #1; seen |= stall[0]; tick();
    set_b(1, 0, 0, 0, 0, 5, 0, 1, 0, 8'h00, 8'h00); tick();
    set_b(1, 1, 2, 6, 7, 0, 1, 0, 0, 8'h00, 8'h00); #1; seen |= stall[0]; tick();
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL nohz_stall: got %b expected 0", seen);
    end
    checks++;
    if (sc_a !== 2'd0 || v[0] !== 1'b1 || rd2[0] !== 3'd7) begin
      errors++; $display("FAIL nohz_state: got sc=%0d v=%b rd2=%0d expected 0 1 7", sc_a, v[0], rd2[0]);
    end
  endtask

  task automatic test_multi_stall();
    int n;
    apply_reset();
    set_b(1, 0, 0, 0, 0, 6, 0, 1, 0, 8'h00, 8'h00); tick();
    set_b(1, 0, 6, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall[1] === 1'b1) n++;
      tick();
      checks++;
      if (v[1] !== 1'b0) begin
        errors++; $display("FAIL ms_bubble%0d: got v=%b expected 0", i, v[1]);
      end
    end
    checks++;
    if (n != 3 || stall[1] !== 1'b0) begin
      errors++; $display("FAIL ms_stall_len: got %0d cycles, now %b expected 3 cycles, now 0", n, stall[1]);
    end
    tick();
    checks++;
    if (v[1] !== 1'b1 || rd1[1] !== 3'd6 || sc_b !== 16'd3) begin
      errors++; $display("FAIL ms_capture: got v=%b rd1=%0d sc=%0d expected 1 6 3", v[1], rd1[1], sc_b);
    end
  endtask

  task automatic test_flush_in_stall();
    apply_reset();
    set_b(1, 0, 0, 0, 0, 6, 0, 1, 0, 8'h00, 8'h00); tick();
    set_b(1, 0, 6, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00);
    tick();
    checks++;
    if (stall[2] !== 1'b1 || sc_c !== 16'd1) begin
      errors++; $display("FAIL fl_in_stall: got stall=%b sc=%0d expected 1 1", stall[2], sc_c);
    end
    flush = 1;
    #1;
    checks++;
    if (stall[2] !== 1'b0) begin
      errors++; $display("FAIL fl_stall_low: got %b expected 0", stall[2]);
    end
    tick();
    flush = 0;
    #1;
    checks++;
    if (v[2] !== 1'b0 || sc_c !== 16'd1 || stall[2] !== 1'b0) begin
      errors++; $display("FAIL fl_after: got v=%b sc=%0d stall=%b expected 0 1 0", v[2], sc_c, stall[2]);
    end
    tick();
    checks++;
    if (v[2] !== 1'b1 || rd1[2] !== 3'd6) begin
      errors++; $display("FAIL fl_capture: got v=%b rd1=%0d expected 1 6", v[2], rd1[2]);
    end
  endtask

  task automatic test_ex_hold();
    apply_reset();
    set_b(1, 4, 0, 0, 0, 0, 1, 0, 0, 8'h3C, 8'h00); tick();
    set_b(1, 1, 0, 0, 0, 0, 1, 0, 0, 8'hA5, 8'h00);
    ex_hold = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (stall[0] !== 1'b1) begin
        errors++; $display("FAIL hold_stall%0d: got %b expected 1", i, stall[0]);
      end
      tick();
      checks++;
      if (rn1[0] !== 3'd4 || c1[0] !== 8'h3C) begin
        errors++; $display("FAIL hold_regs%0d: got rn1=%0d c1=%h expected 4 3c", i, rn1[0], c1[0]);
      end
    end
    ex_hold = 0;
    tick();
    checks++;
    if (rn1[0] !== 3'd1 || c1[0] !== 8'hA5 || sc_a !== 2'd0) begin
      errors++; $display("FAIL hold_release: got rn1=%0d c1=%h sc=%0d expected 1 a5 0", rn1[0], c1[0], sc_a);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_sc;
    apply_reset();
    for (int k = 1; k <= 4; k++) begin
      set_b(1, 0, 0, 0, 0, 5, 0, 1, 0, 8'h00, 8'h00); tick();
      set_b(1, 5, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00); tick();
      exp_sc = (k > 3) ? 2'd3 : 2'(k);
      checks++;
      if (sc_a !== exp_sc) begin
        errors++; $display("FAIL sat_count%0d: got %0d expected %0d", k, sc_a, exp_sc);
      end
    end
  endtask

  initial begin
    rst_n = 0; flush = 0; ex_hold = 0;
    idle();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_multi_stall();
    test_flush_in_stall();
    test_ex_hold();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
